imem_arbiter: RTL

Single-port instruction-memory arbiter placed between the CPU fetch stage, the program-load port and the instruction ROM/RAM inside the CPU. Each cycle it grants the one memory port to either the fetch requester or the loader, and routes the one-cycle-latency read data back to the requester that issued the read. Fetch has priority; a saturating starvation counter bounds the loader's wait. A lock mode lets the loader own the memory exclusively while it reprograms it.

---
 rtl/imem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: one memory port shared between CPU fetch and the
// program loader. Fetch has priority, a saturating starvation counter forces the
// loader through after MAX_WAIT lost cycles, and a lock mode gives the loader
// exclusive ownership while it reprograms the memory. Read data returns one
// cycle after the grant and is steered to whichever side issued the read.
module imem_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  ld_req,
   input  logic                  ld_we,
   input  logic                  ld_lock,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   output logic                  ld_gnt,
   output logic                  ld_rvalid,
   output logic [DATA_WIDTH-1:0] ld_rdata,
   output logic                  locked,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic {ARB, LOCK} state_t;

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   state_t     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       rd_if_p1, rd_ld_p1;

   // Grant decision, next state and starvation bookkeeping; grants are held
   // low while reset is asserted so no access leaks out during reset.
   always_comb begin
      if_gnt   = 1'b0;
      ld_gnt   = 1'b0;
      state_d  = state_q;
      starve_d = starve_q;

      if (rst_n) begin
         if (state_q == LOCK) begin
            ld_gnt = ld_req;
         end else begin
            ld_gnt = ld_req & (!if_req | (starve_q == MAX_W));
            if_gnt = if_req & !ld_gnt;
         end
      end

      // A granted or absent loader request resets the wait; each cycle the
      // loader loses to fetch adds one, saturating at the forcing threshold.
      if (ld_gnt || !ld_req) begin
         starve_d = 4'd0;
      end else if (if_gnt && (starve_q < MAX_W)) begin
         starve_d = starve_q + 4'd1;
      end

      case (state_q)
         ARB:     if (ld_gnt && ld_lock) state_d = LOCK;
         LOCK:    if (!ld_lock)          state_d = ARB;
         default:                        state_d = ARB;
      endcase
   end

   // Memory port driven by whichever requester holds the grant, zero when idle.
   always_comb begin
      mem_en    = if_gnt | ld_gnt;
      mem_we    = ld_gnt & ld_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ld_gnt) begin
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

   // Arbitration state, starvation counter and read-owner flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB;
         starve_q <= 4'd0;
         rd_if_p1 <= 1'b0;
         rd_ld_p1 <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         rd_if_p1 <= if_gnt;
         rd_ld_p1 <= ld_gnt & !ld_we;
      end
   end

   // Response stage: read data returned to the owner recorded at grant time.
   always_comb begin
      if_rvalid = rd_if_p1;
      ld_rvalid = rd_ld_p1;
      if_rdata  = rd_if_p1 ? mem_rdata : '0;
      ld_rdata  = rd_ld_p1 ? mem_rdata : '0;
      locked    = (state_q == LOCK);
   end

endmodule
